// File: rtl/aes_out_collector.sv
// Tags each accepted AES block through a fixed-latency delay line and collects the ciphertext into a FWFT FIFO.
// Credit counter (in flight + stored) gates in_ready so the never-stalling pipe always finds FIFO space.
module aes_out_collector #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_tag,
   input  logic [0:127] aesdata,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data,
   output logic [7:0]   out_tag,
   output logic [6:0]   out_count
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [6:0] DEPTH_C = 7'(DEPTH);

   logic [LATENCY-1:0] dl_vld_q, dl_vld_d;
   logic [7:0]         dl_tag_q [LATENCY];
   logic [7:0]         dl_tag_d [LATENCY];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [6:0]         count_q, count_d, used_q, used_d;
   logic [0:127]       mem_data_q [DEPTH];
   logic [7:0]         mem_tag_q  [DEPTH];
   logic               accept, pop, wr_en;

   assign in_ready  = (used_q < DEPTH_C);
   assign out_valid = (count_q != 7'd0);
   assign out_count = count_q;
   // Head is masked while empty so the outputs read zero out of reset
   assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
   assign out_tag   = out_valid ? mem_tag_q[rd_ptr_q]  : 8'd0;

   always_comb begin
      accept   = in_valid && in_ready;
      pop      = out_valid && out_ready;
      wr_en    = dl_vld_q[LATENCY-1] && (count_q != DEPTH_C);
      dl_vld_d = '0;
      dl_vld_d[0] = accept;
      dl_tag_d[0] = in_tag;
      for (int i = 1; i < LATENCY; i++) begin
         dl_vld_d[i] = dl_vld_q[i-1];
         dl_tag_d[i] = dl_tag_q[i-1];
      end
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 7'd1;
         2'b01:   count_d = count_q - 7'd1;
         default: count_d = count_q;
      endcase
      used_d = used_q;
      case ({accept, pop})
         2'b10:   used_d = used_q + 7'd1;
         2'b01:   used_d = used_q - 7'd1;
         default: used_d = used_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) dl_tag_q[i] <= 8'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 7'd0;
         used_q   <= 7'd0;
      end else begin
         dl_vld_q <= dl_vld_d;
         for (int i = 0; i < LATENCY; i++) dl_tag_q[i] <= dl_tag_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         used_q   <= used_d;
      end
   end

   // Storage needs no reset: entries are only visible once count covers them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data_q[wr_ptr_q] <= aesdata;
         mem_tag_q[wr_ptr_q]  <= dl_tag_q[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_aes_out_collector.sv
// Directed bench for aes_out_collector (LATENCY=10, DEPTH=16) with a tag/data scoreboard on every pop.
module tb_aes_out_collector;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_tag = 8'd0;
   logic [0:127] aesdata = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [0:127] out_data;
   logic [7:0]   out_tag;
   logic [6:0]   out_count;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_n, pop_n;
   bit sb_on = 1'b0;
   bit gap, rdy_drop, seen;
   logic [135:0] exp_q [$];

   aes_out_collector #(.LATENCY(10), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
      .aesdata(aesdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_count(out_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tg, input logic [135:0] act, input logic [135:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tg, act, exp);
      end
   endtask

   // Ciphertext the bench presents just before edge n
   function automatic logic [127:0] dat_f(input int n);
      logic [31:0] w;
      w = 32'(n) * 32'h9E3779B9 ^ 32'h00C0FFEE;
      return {w, ~w, w ^ 32'h5A5A5A5A, 32'(n)};
   endfunction

   // One clock: record accept/pop against the scoreboard, advance, then drive data for the next edge
   task automatic tick;
      bit acc;
      acc = in_valid && in_ready;
      if (sb_on) begin
         if (acc) begin
            exp_q.push_back({dat_f(cyc + 11), in_tag});
            acc_n++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 136'd1, 136'd0);
            else chk("pop_head", {out_data, out_tag}, exp_q.pop_front());
            pop_n++;
         end
      end
      @(posedge clk);
      #1;
      if (sb_on) begin
         if (acc) in_tag = in_tag + 8'd1;
         aesdata = dat_f(cyc + 1);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_tag = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      acc_n = 0;
      pop_n = 0;
      aesdata = sb_on ? dat_f(cyc + 1) : '0;
   endtask

   initial begin
      // Reset values
      #3;
      chk("rst_in_ready",  136'(in_ready),  136'd1);
      chk("rst_out_valid", 136'(out_valid), 136'd0);
      chk("rst_out_count", 136'(out_count), 136'd0);
      chk("rst_out_data",  136'(out_data),  136'd0);
      chk("rst_out_tag",   136'(out_tag),   136'd0);

      // Single block with the known ciphertext, written ten edges after acceptance
      sb_on = 1'b0;
      do_reset();
      in_valid = 1'b1;
      in_tag = 8'h01;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("single_not_early", 136'(out_valid), 136'd0);
      aesdata = 128'h3925841d02dc09fbdc118597196a0b32;
      tick();
      chk("single_valid", 136'(out_valid), 136'd1);
      chk("single_data",  136'(out_data),  136'(128'h3925841d02dc09fbdc118597196a0b32));
      chk("single_tag",   136'(out_tag),   136'h01);
      chk("single_count", 136'(out_count), 136'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_popped", 136'(out_valid), 136'd0);
      chk("single_count0", 136'(out_count), 136'd0);

      // Backpressure: consumer stalled, source always valid
      sb_on = 1'b1;
      do_reset();
      in_valid = 1'b1;
      repeat (40) tick();
      chk("bp_accepts",  136'(acc_n),     136'd16);
      chk("bp_in_ready", 136'(in_ready),  136'd0);
      chk("bp_count",    136'(out_count), 136'd16);

      // Drain from full; credit comes back right after the first pop
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("drain_in_ready", 136'(in_ready),  136'd1);
      chk("drain_count15",  136'(out_count), 136'd15);
      repeat (15) tick();
      chk("drain_empty", 136'(out_valid), 136'd0);
      chk("drain_pops",  136'(pop_n),     136'd16);
      chk("drain_sb",    136'(exp_q.size()), 136'd0);

      // Streaming: 100 blocks with the consumer always ready
      do_reset();
      out_ready = 1'b1;
      gap = 1'b0;
      rdy_drop = 1'b0;
      for (int i = 0; i < 200 && pop_n < 100; i++) begin
         in_valid = (acc_n < 100);
         if (in_valid && !in_ready) rdy_drop = 1'b1;
         if (pop_n > 0 && !out_valid) gap = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("stream_pops",  136'(pop_n),    136'd100);
      chk("stream_gap",   136'(gap),      136'd0);
      chk("stream_ready", 136'(rdy_drop), 136'd0);

      // Reset mid-flight: 3 stored, 5 still in the delay line
      do_reset();
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (5) tick();
      in_valid = 1'b1;
      repeat (5) tick();
      in_valid = 1'b0;
      chk("mid_count3", 136'(out_count), 136'd3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 136'(out_valid), 136'd0);
      chk("mid_rst_count", 136'(out_count), 136'd0);
      chk("mid_rst_ready", 136'(in_ready),  136'd1);
      #1 rst = 1'b0;
      exp_q.delete();
      seen = 1'b0;
      repeat (20) begin
         if (out_valid || out_count != 7'd0) seen = 1'b1;
         tick();
      end
      chk("mid_no_output", 136'(seen), 136'd0);

      // Empty-FIFO boundary: write with out_ready high shows the entry one cycle later
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("empty_pre_valid", 136'(out_valid), 136'd0);
      tick();
      chk("empty_valid", 136'(out_valid), 136'd1);
      chk("empty_count", 136'(out_count), 136'd1);
      chk("empty_sb_held", 136'(exp_q.size()), 136'd1);
      tick();
      chk("empty_popped", 136'(out_count), 136'd0);
      chk("empty_pops",   136'(pop_n),     136'd1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
